d8_regfile_ctx: RTL and testbench

Context save/restore engine and port arbiter for the d8 16x8 register file.
- In normal operation it passes the core's read-A and write ports straight through.
- On request it takes the register file over, stalls the core, and streams all registers out (save) or in (restore) over valid/ready handshakes.
- Sits between the core decode/writeback logic and d8_registers; the stream side attaches to the debug/context-switch unit.

---
 rtl/d8_pkg.sv | 16 +
 rtl/d8_regfile_ctx.sv | 112 +++++++++++
 tb/tb_d8_regfile_ctx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/d8_pkg.sv
// Shared constants and state encoding for the d8 context engine.
// Register count, index/data widths and FSM state type.
package d8_pkg;

  localparam int D8_NREGS = 16;
  localparam int D8_AW    = 4;
  localparam int D8_DW    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/d8_regfile_ctx.sv
// Context save/restore engine and port arbiter for the d8 register file.
// Ports: sys_clk/sys_rst; cpu_* core side; rf_* register file side;
// save_req/restore_req, busy/done/cpu_stall; out_* save stream; in_* restore stream.
module d8_regfile_ctx
  import d8_pkg::*;
#(
  parameter int NUM_REGS = D8_NREGS,
  parameter int AW       = D8_AW,
  parameter int DW       = D8_DW
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [AW-1:0] cpu_addr_a,
  input  logic [AW-1:0] cpu_addr_w,
  input  logic          cpu_w,
  input  logic [DW-1:0] cpu_data,
  output logic [AW-1:0] rf_addr_a,
  output logic [AW-1:0] rf_addr_w,
  output logic          rf_w,
  output logic [DW-1:0] rf_data,
  input  logic [DW-1:0] rf_qa,
  input  logic          save_req,
  input  logic          restore_req,
  output logic          busy,
  output logic          done,
  output logic          cpu_stall,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data
);

  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  state_t        state;
  logic [AW-1:0] idx;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (save_req) begin
            state <= ST_SAVE;
            idx   <= '0;
          end else if (restore_req) begin
            state <= ST_RESTORE;
            idx   <= '0;
          end
        end
        // Terminal check comes before the increment so idx never wraps.
        ST_SAVE: begin
          if (out_ready) begin
            if (idx == LAST) state <= ST_DONE;
            else idx <= idx + 1'b1;
          end
        end
        ST_RESTORE: begin
          if (in_valid) begin
            if (idx == LAST) state <= ST_DONE;
            else idx <= idx + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status decodes straight from the state register, so an async
  // reset drops them without waiting for a clock edge.
  assign busy      = (state != ST_IDLE);
  assign cpu_stall = busy;
  assign done      = (state == ST_DONE);
  assign out_valid = (state == ST_SAVE);
  assign in_ready  = (state == ST_RESTORE);
  assign out_idx   = idx;
  assign out_data  = rf_qa;

  always_comb begin
    rf_addr_a = cpu_addr_a;
    rf_addr_w = cpu_addr_w;
    rf_w      = cpu_w;
    rf_data   = cpu_data;
    unique case (state)
      ST_IDLE: ;
      ST_SAVE: begin
        rf_addr_a = idx;
        rf_addr_w = idx;
        rf_w      = 1'b0;
        rf_data   = in_data;
      end
      ST_RESTORE: begin
        rf_addr_w = idx;
        rf_w      = in_valid;
        rf_data   = in_data;
      end
      ST_DONE: begin
        rf_addr_w = idx;
        rf_w      = 1'b0;
        rf_data   = in_data;
      end
      default: rf_w = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_d8_regfile_ctx.sv
// Randomized self-checking bench for d8_regfile_ctx.
// Behavioural register file plus an expected-contents array as reference.
module tb_d8_regfile_ctx;
  import d8_pkg::*;

  localparam int N = D8_NREGS;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] cpu_addr_a, cpu_addr_w;
  logic       cpu_w;
  logic [7:0] cpu_data;
  logic [3:0] rf_addr_a, rf_addr_w;
  logic       rf_w;
  logic [7:0] rf_data, rf_qa;
  logic       save_req, restore_req;
  logic       busy, done, cpu_stall;
  logic       out_valid, out_ready;
  logic [3:0] out_idx;
  logic [7:0] out_data;
  logic       in_valid, in_ready;
  logic [7:0] in_data;

  logic [7:0] rf_mem [N];
  logic [7:0] exp_rf [N];

  int n_chk = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  assign rf_qa = rf_mem[rf_addr_a];

  always @(posedge sys_clk) if (rf_w) rf_mem[rf_addr_w] <= rf_data;

  d8_regfile_ctx dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cpu_addr_a(cpu_addr_a), .cpu_addr_w(cpu_addr_w),
    .cpu_w(cpu_w), .cpu_data(cpu_data),
    .rf_addr_a(rf_addr_a), .rf_addr_w(rf_addr_w),
    .rf_w(rf_w), .rf_data(rf_data), .rf_qa(rf_qa),
    .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done), .cpu_stall(cpu_stall),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic rand_cpu();
    cpu_w      = 1'($urandom);
    cpu_addr_w = 4'($urandom);
    cpu_addr_a = 4'($urandom);
    cpu_data   = 8'($urandom);
  endtask

  task automatic cpu_write(input int a, input logic [7:0] d);
    @(negedge sys_clk);
    cpu_w = 1'b1;
    cpu_addr_w = 4'(a);
    cpu_data = d;
    #1;
    chk("wr_pass_w", 32'(rf_w), 32'd1);
    chk("wr_pass_a", 32'(rf_addr_w), 32'(a));
    exp_rf[a] = d;
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < N; i++) begin
      @(negedge sys_clk);
      cpu_w = 1'b0;
      cpu_addr_a = 4'(i);
      #1;
      chk({tag, "_rd"}, 32'(rf_qa), 32'(exp_rf[i]));
    end
  endtask

  task automatic finish_op(input string tag, input int cyc,
                           input int stalls, input int beat, input bit got);
    chk({tag, "_got_done"}, 32'(got), 32'd1);
    chk({tag, "_done_cyc"}, 32'(cyc), 32'(N + stalls + 1));
    chk({tag, "_beats"}, 32'(beat), 32'(N));
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    @(negedge sys_clk);
    cpu_w = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    #1;
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_stall_end"}, 32'(cpu_stall), 32'd0);
  endtask

  // mode: 0 always ready, 1 toggling, 2 random
  task automatic run_save(input int mode, input bit both, input bit wr3);
    int cyc, beat, stalls;
    bit got;
    @(negedge sys_clk);
    save_req = 1'b1;
    restore_req = both;
    cpu_w = wr3;
    cpu_addr_w = 4'd3;
    cpu_data = 8'h55;
    if (wr3) exp_rf[3] = 8'h55;
    #1;
    chk("acc_pass_w", 32'(rf_w), 32'(wr3));
    cyc = 0; beat = 0; stalls = 0; got = 0;
    while (!got && cyc < 100) begin
      @(negedge sys_clk);
      cyc++;
      save_req = 1'b0;
      restore_req = 1'b0;
      rand_cpu();
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'(cyc % 2);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (done) got = 1;
      else begin
        chk("sv_valid", 32'(out_valid), 32'd1);
        chk("sv_stall", 32'(cpu_stall), 32'd1);
        chk("sv_in_ready", 32'(in_ready), 32'd0);
        chk("sv_rf_w", 32'(rf_w), 32'd0);
        if (beat < N) begin
          chk("sv_idx", 32'(out_idx), 32'(beat));
          chk("sv_data", 32'(out_data), 32'(exp_rf[beat]));
        end
        if (out_ready) beat++;
        else stalls++;
      end
    end
    finish_op("sv", cyc, stalls, beat, got);
  endtask

  // abort_at < 0: run to completion; else reset after that many beats
  task automatic run_restore(input int mode, input bit seq, input int abort_at);
    int cyc, beat, stalls;
    bit got;
    @(negedge sys_clk);
    restore_req = 1'b1;
    save_req = 1'b0;
    cpu_w = 1'b0;
    cyc = 0; beat = 0; stalls = 0; got = 0;
    while (!got && cyc < 100) begin
      @(negedge sys_clk);
      cyc++;
      restore_req = 1'b0;
      if (abort_at >= 0 && beat == abort_at) begin
        in_valid = 1'b0;
        cpu_w = 1'b0;
        #2 sys_rst = 1'b1;
        #1;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_in_ready", 32'(in_ready), 32'd0);
        chk("ab_stall", 32'(cpu_stall), 32'd0);
        chk("ab_idx", 32'(out_idx), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        chk("ab_idle", 32'(busy), 32'd0);
        return;
      end
      rand_cpu();
      case (mode)
        0: in_valid = 1'b1;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = seq ? 8'(8'hA0 + beat) : 8'($urandom);
      #1;
      if (done) got = 1;
      else begin
        chk("rs_in_ready", 32'(in_ready), 32'd1);
        chk("rs_out_valid", 32'(out_valid), 32'd0);
        chk("rs_stall", 32'(cpu_stall), 32'd1);
        chk("rs_rf_w", 32'(rf_w), 32'(in_valid));
        if (in_valid) begin
          chk("rs_addr", 32'(rf_addr_w), 32'(beat));
          chk("rs_data", 32'(rf_data), 32'(in_data));
          if (beat < N) exp_rf[beat] = in_data;
          beat++;
        end else stalls++;
      end
    end
    finish_op("rs", cyc, stalls, beat, got);
  endtask

  initial begin
    cpu_addr_a = 4'd0; cpu_addr_w = 4'd9; cpu_w = 1'b1; cpu_data = 8'h3C;
    save_req = 1'b0; restore_req = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge sys_clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_pass_aw", 32'(rf_addr_w), 32'd9);
    chk("rst_pass_d", 32'(rf_data), 32'h3C);
    cpu_w = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;

    for (int i = 0; i < N; i++) cpu_write(i, 8'(8'h10 + i));
    readback("pre");
    run_save(0, 1'b0, 1'b0);
    run_save(1, 1'b0, 1'b0);
    run_restore(0, 1'b1, -1);
    readback("rs1");
    run_save(2, 1'b1, 1'b0);
    run_restore(0, 1'b0, 5);
    readback("ab");
    run_save(0, 1'b0, 1'b1);
    readback("w3");
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 1) == 1) run_save(2, 1'b0, 1'b0);
      else run_restore(1, 1'b0, -1);
      readback("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
